// File: rtl/sign_ext_pkg.sv
// Shared immediate-path types and widths for the 12-to-17-bit extender.
package sign_ext_pkg;

    localparam int IMM_IN_W  = 12;
    localparam int IMM_EXT_W = 5;
    localparam int IMM_OUT_W = IMM_IN_W + IMM_EXT_W;

    typedef logic [IMM_IN_W-1:0]  imm12_t;
    typedef logic [IMM_OUT_W-1:0] imm17_t;

    typedef enum logic {
        EXT_SIGN = 1'b0,
        EXT_ZERO = 1'b1
    } ext_mode_e;

endpackage

// File: rtl/sign_ext_core.sv
// Pure combinational extender: the low bits pass through and the top bits
// take either a copy of the input's top bit or zero.
module sign_ext_core
    import sign_ext_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int EXT_W = IMM_EXT_W
) (
    input  logic [IN_W-1:0]       in_data,
    input  logic                  zext,
    output logic [IN_W+EXT_W-1:0] ext
);

    ext_mode_e mode;
    logic      fill_bit;

    assign mode     = ext_mode_e'(zext);
    assign fill_bit = (mode == EXT_ZERO) ? 1'b0 : in_data[IN_W-1];

    assign ext[IN_W-1:0] = in_data;

    generate
        for (genvar gi = 0; gi < EXT_W; gi++) begin : g_fill
            assign ext[IN_W+gi] = fill_bit;
        end
    endgenerate

endmodule

// File: rtl/sign_ext_5.sv
// Immediate extender with one-cycle registered output and a valid qualifier.
// Define SIGN_EXT_5_COMB_EN to bypass the register and get a zero-latency path.
module sign_ext_5
    import sign_ext_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int EXT_W = IMM_EXT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  zext,
    output logic                  out_valid,
    output logic [IN_W+EXT_W-1:0] out_data,
    output logic                  out_neg
);

    localparam int OUT_W = IN_W + EXT_W;

    logic [OUT_W-1:0] ext;

    sign_ext_core #(
        .IN_W  (IN_W),
        .EXT_W (EXT_W)
    ) u_core (
        .in_data (in_data),
        .zext    (zext),
        .ext     (ext)
    );

`ifdef SIGN_EXT_5_COMB_EN

    assign out_valid = in_valid & rst_n;
    assign out_data  = ext;
    assign out_neg   = ext[OUT_W-1];

`else

    logic [1:0]       rst_sync_reg;
    logic             out_valid_reg;
    logic [OUT_W-1:0] out_data_reg;
    logic             out_neg_reg;

    // Reset asserts immediately but releases only after two clean edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    // Data and sign hold while idle so downstream muxes see no spurious toggles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_neg_reg   <= 1'b0;
        end else if (!rst_sync_reg[1]) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_neg_reg   <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                out_data_reg <= ext;
                out_neg_reg  <= ext[OUT_W-1];
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_neg   = out_neg_reg;

`endif

endmodule

// File: tb/tb_sign_ext_5.sv
// Directed bench for sign_ext_5: reset, sign/zero extension, boundaries, hold, async reset.
module tb_sign_ext_5;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_data;
    logic        zext;
    logic        out_valid;
    logic [16:0] out_data;
    logic        out_neg;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [11:0] in_data;
        logic        zext;
        logic        in_valid;
        logic        exp_valid;
        logic [16:0] exp_data;
        logic        exp_neg;
    } vec_t;

    vec_t vecs[10];

    sign_ext_5 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .zext      (zext),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_neg   (out_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%05h, expected 0x%05h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic ev, input logic [16:0] ed,
                              input logic en);
        check({name, ".valid"}, {16'd0, out_valid}, {16'd0, ev});
        check({name, ".data"},  out_data, ed);
        check({name, ".neg"},   {16'd0, out_neg}, {16'd0, en});
        $display("[TB] %s: valid=%0b data=0x%05h neg=%0b", name, out_valid, out_data, out_neg);
    endtask

    task automatic drive(input logic v, input logic [11:0] d, input logic z);
        in_valid = v;
        in_data  = d;
        zext     = z;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{12'h729, 1'b0, 1'b1, 1'b1, 17'h00729, 1'b0};
        vecs[1] = '{12'h7FF, 1'b0, 1'b1, 1'b1, 17'h007FF, 1'b0};
        vecs[2] = '{12'h800, 1'b0, 1'b1, 1'b1, 17'h1F800, 1'b1};
        vecs[3] = '{12'hFFF, 1'b0, 1'b1, 1'b1, 17'h1FFFF, 1'b1};
        vecs[4] = '{12'h000, 1'b0, 1'b1, 1'b1, 17'h00000, 1'b0};
        vecs[5] = '{12'h800, 1'b1, 1'b1, 1'b1, 17'h00800, 1'b0};
        vecs[6] = '{12'hFFF, 1'b0, 1'b0, 1'b0, 17'h00800, 1'b0};
        vecs[7] = '{12'h123, 1'b1, 1'b1, 1'b1, 17'h00123, 1'b0};
        vecs[8] = '{12'hA5A, 1'b1, 1'b0, 1'b0, 17'h00123, 1'b0};
        vecs[9] = '{12'hA5A, 1'b0, 1'b1, 1'b1, 17'h1FA5A, 1'b1};

        rst_n = 1'b0;
        drive(1'b1, 12'h8D7, 1'b0);

`ifdef SIGN_EXT_5_COMB_EN
        #1;
        check_outs("comb_reset", 1'b0, 17'h1F8D7, 1'b1);
        rst_n = 1'b1;
        #1;
        check_outs("comb_8d7", 1'b1, 17'h1F8D7, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].in_valid, vecs[i].in_data, vecs[i].zext);
            #1;
            check_outs($sformatf("comb_vec%0d", i), vecs[i].in_valid,
                       {{5{~vecs[i].zext & vecs[i].in_data[11]}}, vecs[i].in_data},
                       ~vecs[i].zext & vecs[i].in_data[11]);
        end
`else
        // Reset held with valid input: outputs stay clear across several edges.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_outs($sformatf("reset_hold%0d", i), 1'b0, 17'h00000, 1'b0);
        end

        // Release between edges; the first edge after release must not load.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outs("release_edge1", 1'b0, 17'h00000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outs("sign_neg_8d7", 1'b1, 17'h1F8D7, 1'b1);

        // Back-to-back table: each vector appears one edge after it is applied.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].in_valid, vecs[i].in_data, vecs[i].zext);
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d_%03h", i, vecs[i].in_data),
                       vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_neg);
        end

        // Async reset between edges clears the outputs before the next edge.
        @(negedge clk);
        drive(1'b1, 12'h8D7, 1'b0);
        @(posedge clk);
        #1;
        check_outs("pre_async", 1'b1, 17'h1F8D7, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_clear", 1'b0, 17'h00000, 1'b0);
        @(posedge clk);
        #1;
        check_outs("async_hold", 1'b0, 17'h00000, 1'b0);

        // Recovery after a mid-stream reset.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 12'h729, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_outs("recover_729", 1'b1, 17'h00729, 1'b0);
`endif

        drive(1'b0, 12'h000, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sign_ext_5.md
Name: sign_ext_5

Overview:
- Widens a 12-bit two's-complement immediate to 17 bits by replicating bit 11 into the five new MSBs.
- Used in the KGP-RISC datapath immediate path, between the instruction-field decode and the ALU operand mux.
- Registered by default: one-cycle latency with a valid qualifier.
- Also supports zero-extension through a mode input.

Parameters:
- IN_W, 12, input field width; must be ≥ 2.
- EXT_W, 5, number of bits added; OUT_W = IN_W + EXT_W = 17.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is meaningful this cycle.
- in_data  input  IN_W  raw immediate field.
- zext  input  1  0 = sign-extend, 1 = zero-extend; sampled with in_data.
- out_valid  output  1  out_data holds a result.
- out_data  output  OUT_W  extended value.
- out_neg  output  1  out_data[OUT_W-1]; set only for a sign-extended negative input.

Behaviour:
- Extension function, for a given input field:
  - Sign mode: ext = {EXT_W{in_data[IN_W-1]}, in_data}.
  - Zero mode: ext = {EXT_W'b0, in_data}.
- Low IN_W bits of out_data always equal in_data; only the top EXT_W bits depend on mode.
- Reset (rst_n low, asynchronous assert): out_valid=0, out_data=0, out_neg=0.
- Reset deassertion is synchronised internally by a 2-flop release.
- Registered path: on each rising clk with in_valid=1, the outputs load on that edge:
  - out_data ← ext;
  - out_neg ← ext[OUT_W-1];
  - out_valid ← 1.
- Latency is exactly 1 cycle.
- On a clk edge with in_valid=0:
  - out_valid ← 0;
  - out_data and out_neg hold their last values (no gratuitous toggling).
- Back-to-back valid inputs: one result per cycle, in order.
- There is no backpressure.
- Reset asserted mid-stream: the pending result is discarded and the outputs clear immediately.
- Boundary values (sign mode):
  - 0x7FF → 0x007FF;
  - 0x800 → 0x1F800;
  - 0xFFF → 0x1FFFF;
  - 0x000 → 0x00000.
- Wider upstream values are truncated to IN_W by the caller. The block sees only in_data.
- zext has no effect when in_data[IN_W-1]=0.

Optional Feature:
- Macro: SIGN_EXT_5_COMB_EN.
- Defined:
  - out_data = ext and out_neg = ext[OUT_W-1], purely combinationally from in_data/zext (zero latency).
  - out_valid = in_valid combinationally.
  - clk/rst_n are unused except that reset still forces out_valid=0.
- Undefined: registered behaviour as above.

Decomposition:
- Shared package sign_ext_pkg holds:
  - localparams IMM_IN_W=12, IMM_EXT_W=5, IMM_OUT_W=17;
  - typedef imm12_t (logic [11:0]);
  - typedef imm17_t (logic [16:0]);
  - enum ext_mode_e {EXT_SIGN=0, EXT_ZERO=1}.
- One natural sub-module: sign_ext_core. It is the pure combinational extender (in_data, zext → ext).
- The top wraps sign_ext_core with the output register, the reset synchroniser and the macro-selected bypass.

Test Plan:
- Reset: hold rst_n=0 while driving in_valid=1, in_data=0x8D7 → out_valid=0, out_data=0, out_neg=0 throughout.
- Sign, negative: in_data=0x8D7 (low 12 bits of 10455), zext=0, in_valid=1 → next cycle out_data=0x1F8D7 (129239 unsigned), out_neg=1, out_valid=1.
- Sign, positive: in_data=0x729 (low 12 bits of -10455) → out_data=0x00729 (1833), out_neg=0.
- Boundaries streamed back-to-back: 0x7FF, 0x800, 0xFFF, 0x000 → 0x007FF, 0x1F800, 0x1FFFF, 0x00000 on consecutive cycles.
- Zero mode: in_data=0x800, zext=1 → out_data=0x00800, out_neg=0. Next drop in_valid=0 → out_valid=0, out_data holds 0x00800.
- Async reset mid-stream: assert rst_n low between clock edges after a valid input → outputs clear immediately, before the next edge. With SIGN_EXT_5_COMB_EN defined, 0x8D7 yields 0x1F8D7 in the same cycle.
